frame_reverser: RTL
===================

Name: frame_reverser

Overview:
- Byte-stream buffer that collects one frame of up to DEPTH bytes, then replays it in reverse order (LIFO).
- Partner to the byte delay-line shift register. The delay line preserves order at fixed latency; this block reverses order with frame-dependent latency.
- Sits between a ui_in byte source and a uo_out byte sink.
- Uses valid/ready handshakes on both sides, so it can be chained behind or ahead of the delay line inside a tt_um wrapper.

Parameters:
- DEPTH, 20, maximum frame length in bytes (storage entries).
- WIDTH, 8, data width in bits.
- CNT_W, 5, counter width; must be at least clog2(DEPTH+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  WIDTH  input byte.
- in_valid  in  1  in_data is valid.
- in_last  in  1  qualifies in_data as the final byte of the frame.
- in_ready  out  1  block accepts input this cycle.
- out_data  out  WIDTH  output byte.
- out_valid  out  1  out_data is valid.
- out_last  out  1  out_data is the final byte of the reversed frame.
- out_ready  in  1  sink accepts output this cycle.
- level  out  CNT_W  bytes currently held.
- trunc  out  1  one-cycle pulse: frame closed by full buffer, not by in_last.

Behaviour:
- Reset values (async assert, sync release):
  - state = FILL, level = 0, read pointer = 0, all storage entries = 0, trunc = 0.
  - Outputs: in_ready = 1, out_valid = 0, out_last = 0, out_data = 0.
- Two-state FSM, FILL and DRAIN.
- Input accept: in_valid & in_ready.
- FILL state:
  - in_ready = 1, out_valid = 0.
  - On accept: mem[level] <= in_data; level <= level + 1.
  - If the accepted byte has in_last = 1, or level == DEPTH-1, go to DRAIN next cycle.
  - Read pointer loads level (new value, i.e. index of the last written byte + 1) on that transition.
  - Full without in_last: trunc = 1 for exactly the first DRAIN cycle. The rest of the source frame is taken as the start of the next frame.
- DRAIN state:
  - in_ready = 0; in_valid is ignored and nothing is written.
  - out_valid = 1; out_data = mem[rdptr-1]; out_last = (rdptr == 1).
  - On out_valid & out_ready: rdptr <= rdptr - 1, level <= level - 1.
  - On the transfer with out_last: go to FILL next cycle, level = 0.
- Output stability: out_data and out_last hold while out_valid & !out_ready.
- Latency: first reversed byte is presented the cycle after the last input accept. Minimum turnaround for a 1-byte frame is 2 cycles from accept to in_ready high again, with out_ready = 1.
- No overlap: a new frame cannot be accepted during DRAIN. Throughput is one byte per cycle per phase.
- in_last is ignored when in_valid = 0.
- Zero-length frames cannot occur.
- Storage is not cleared between frames; stale entries are never read.
- level saturates at DEPTH and never wraps; rdptr never underflows.
- Reset mid-FILL or mid-DRAIN: immediate return to the reset values; the partial frame is discarded.

Decomposition:
- Shared package frame_pkg holds:
  - DEPTH_DEFAULT = 20 and WIDTH_DEFAULT = 8;
  - state encoding FILL = 1'b0, DRAIN = 1'b1.
- One sub-module, frame_store: DEPTH x WIDTH register array with async reset clear, write port (we, waddr, wdata) and combinational read port (raddr, rdata).
- FSM, counters and handshake logic stay in frame_reverser.

Test Plan:
- Reset: hold rst 3 cycles with in_valid = 1 -> in_ready = 1, out_valid = 0, level = 0, trunc = 0; after release, accept begins on the first edge.
- Basic reverse: send 0x11, 0x22, 0x33 (last on 0x33), out_ready = 1 -> outputs 0x33, 0x22, 0x11 on consecutive cycles, out_last only with 0x11; in_ready = 0 for exactly those 3 cycles.
- Truncation: stream 0x00..0x18 with no in_last:
  - 0x00..0x13 accepted; trunc pulses once.
  - Output is 0x13 down to 0x00, with out_last on 0x00.
  - 0x14..0x18 accepted after the drain; level reads 5.
- Backpressure: 4-byte frame 0xA0..0xA3, out_ready toggling 1,0,0,1,0,1,1 -> out_data holds on each stall; sink receives exactly 0xA3, 0xA2, 0xA1, 0xA0.
- Reset mid-DRAIN: frame 0x01, 0x02, 0x03; assert rst after 0x03 is delivered -> out_valid = 0 immediately, level = 0; next frame 0x55 (last) yields single output 0x55 with out_last.
- Single byte: 0xA5 with in_last -> next cycle out_valid = 1, out_data = 0xA5, out_last = 1; in_ready returns high the cycle after the transfer.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared defaults and state encoding for the frame reverser and its storage.
package frame_pkg;

  localparam int DEPTH_DEFAULT = 20;
  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/frame_store.sv
// DEPTH x WIDTH register file: one synchronous write port, one combinational read port.
module frame_store
  import frame_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [CNT_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [CNT_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] w_mem [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q <= '0;
      end else if (i_we && (i_waddr == CNT_W'(gi))) begin
        r_q <= i_wdata;
      end
    end

    assign w_mem[gi] = r_q;
  end

  // Out-of-range addresses read as zero instead of indexing past the array.
  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_raddr == CNT_W'(i)) begin
        o_rdata = w_mem[i];
      end
    end
  end

endmodule

// File: rtl/frame_reverser.sv
// Collects one byte frame (closed by last or by a full buffer) and replays it in reverse.
module frame_reverser
  import frame_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  input  logic             i_in_last,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  output logic             o_out_last,
  input  logic             i_out_ready,
  output logic [CNT_W-1:0] o_level,
  output logic             o_trunc
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  state_t           r_state, r_state_next;
  logic [CNT_W-1:0] r_level, r_level_next;
  logic [CNT_W-1:0] r_rdptr, r_rdptr_next;
  logic             r_trunc, r_trunc_next;

  logic             w_we;
  logic [CNT_W-1:0] w_raddr;
  logic [WIDTH-1:0] w_rdata;

  assign w_raddr = r_rdptr - ONE;

  frame_store #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (r_level),
    .i_wdata (i_in_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
      r_level <= '0;
      r_rdptr <= '0;
      r_trunc <= 1'b0;
    end else begin
      r_state <= r_state_next;
      r_level <= r_level_next;
      r_rdptr <= r_rdptr_next;
      r_trunc <= r_trunc_next;
    end
  end

  always_comb begin
    r_state_next = r_state;
    r_level_next = r_level;
    r_rdptr_next = r_rdptr;
    r_trunc_next = 1'b0;
    w_we         = 1'b0;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    o_out_last   = 1'b0;
    o_out_data   = '0;

    case (r_state)
      FILL: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_we         = 1'b1;
          r_level_next = r_level + ONE;
          // rdptr points one past the newest byte so the drain starts there.
          if (i_in_last || (r_level == LAST_IDX)) begin
            r_state_next = DRAIN;
            r_rdptr_next = r_level + ONE;
            r_trunc_next = !i_in_last;
          end
        end
      end
      DRAIN: begin
        o_out_valid = 1'b1;
        o_out_data  = w_rdata;
        o_out_last  = (r_rdptr == ONE);
        if (i_out_ready) begin
          r_rdptr_next = r_rdptr - ONE;
          r_level_next = r_level - ONE;
          if (r_rdptr == ONE) begin
            r_state_next = FILL;
            r_level_next = '0;
          end
        end
      end
      default: r_state_next = FILL;
    endcase
  end

  assign o_level = r_level;
  assign o_trunc = r_trunc;

endmodule
